// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address and
// holds one fetched word in a buffer handed to decode via valid/ready.
module fetch_controller #(
    parameter int ADDR_WIDTH  = 12,
    parameter int INSTR_WIDTH = 32,
    parameter int RESET_PC    = 0,
    parameter int END_ADDR    = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic                   halted
);

    typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;

    // One extra PC bit so END_ADDR == 2**ADDR_WIDTH is reachable without wrap
    localparam logic [ADDR_WIDTH:0] END_PC = (ADDR_WIDTH+1)'(END_ADDR);
    localparam logic [ADDR_WIDTH:0] RST_PC = (ADDR_WIDTH+1)'(RESET_PC);

    state_t                   state, state_n;
    logic [ADDR_WIDTH:0]      pc, pc_n;
    logic                     valid_n;
    logic [ADDR_WIDTH-1:0]    opc_n;
    logic [INSTR_WIDTH-1:0]   oinstr_n;
    logic                     halted_n;
    logic                     take, load, at_end;

    assign at_end   = (pc >= END_PC);
    assign take     = out_valid & out_ready;
    assign load     = (state == FETCH) & !at_end & (!out_valid | out_ready);
    assign rom_addr = pc[ADDR_WIDTH-1:0];

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        valid_n  = out_valid;
        opc_n    = out_pc;
        oinstr_n = out_instr;
        if (redirect_valid) begin
            state_n = FETCH;
            valid_n = 1'b0;
            pc_n    = {1'b0, redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end else begin
            unique case (state)
                FETCH: begin
                    if (load) begin
                        opc_n    = pc[ADDR_WIDTH-1:0];
                        oinstr_n = rom_data;
                        valid_n  = 1'b1;
                        pc_n     = pc + (ADDR_WIDTH+1)'(4);
                    end else if (at_end) begin
                        if (out_valid & !out_ready) begin
                            state_n = DRAIN;
                        end else begin
                            state_n = HALT;
                            valid_n = 1'b0;
                        end
                    end else if (take) begin
                        valid_n = 1'b0;
                    end
                end
                DRAIN: begin
                    if (take) begin
                        valid_n = 1'b0;
                        state_n = HALT;
                    end
                end
                HALT: begin
                    valid_n = 1'b0;
                end
                default: begin
                    state_n = FETCH;
                    valid_n = 1'b0;
                end
            endcase
        end
        halted_n = (state_n == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RST_PC;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_instr <= '0;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            out_valid <= valid_n;
            out_pc    <= opc_n;
            out_instr <= oinstr_n;
            halted    <= halted_n;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a behavioural model.
module tb_fetch_controller;

    localparam int AW  = 12;
    localparam int IW  = 32;
    localparam int END = 48;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [IW-1:0] out_instr;
    logic          halted;

    int checks = 0;
    int errors = 0;

    fetch_controller #(
        .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(0), .END_ADDR(END)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .halted(halted)
    );

    function automatic logic [IW-1:0] rom_word(input int a);
        logic [31:0] x;
        x = 32'(a);
        return {x[11:0], 20'h5A5A5} ^ (x * 32'h9E3779B1);
    endfunction

    assign rom_data = rom_word(int'(rom_addr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Behavioural model: a PC, a one-slot buffer and a stopped flag
    int           m_pc;
    bit           m_val;
    int           m_bpc;
    logic [IW-1:0] m_instr;
    bit           m_halt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_val = 0; m_bpc = 0; m_instr = '0; m_halt = 0;
        end else if (redirect_valid) begin
            m_val = 0;
            m_halt = 0;
            m_pc = int'(redirect_pc) & ~3;
        end else if (!m_halt) begin
            if (m_pc >= END) begin
                if (!m_val || out_ready) begin
                    m_val = 0;
                    m_halt = 1;
                end
            end else if (!m_val || out_ready) begin
                m_bpc = m_pc;
                m_instr = rom_word(m_pc);
                m_val = 1;
                m_pc = m_pc + 4;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_valid", 64'(out_valid), 64'(m_val));
        chk("m_halted", 64'(halted), 64'(m_halt));
        chk("m_rom_addr", 64'(rom_addr), 64'(m_pc[AW-1:0]));
        if (m_val) begin
            chk("m_out_pc", 64'(out_pc), 64'(m_bpc));
            chk("m_out_instr", 64'(out_instr), 64'(m_instr));
        end
    end

    task automatic wait_pc(input int target);
        bit found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (out_valid && int'(out_pc) == target) found = 1;
        end
        chk("wait_pc", 64'(found), 64'd1);
    endtask

    task automatic redirect_to(input int target);
        redirect_valid = 1'b1;
        redirect_pc = AW'(target);
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;
        #3;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Free run over the whole image
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("run_valid", 64'(out_valid), 64'd1);
            chk("run_pc", 64'(out_pc), 64'(i * 4));
            chk("run_instr", 64'(out_instr), 64'(rom_word(i * 4)));
        end
        repeat (2) begin
            @(negedge clk);
            chk("end_valid", 64'(out_valid), 64'd0);
            chk("end_halted", 64'(halted), 64'd1);
        end

        // Redirect to END_ADDR from HALT: one non-halted cycle, no output
        redirect_to(12'h030);
        chk("r30_halted", 64'(halted), 64'd0);
        chk("r30_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("r30_halted2", 64'(halted), 64'd1);
        chk("r30_valid2", 64'(out_valid), 64'd0);

        // Resume from HALT at 0x10
        redirect_to(12'h010);
        chk("r10_gap", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("r10_pc", 64'(out_pc), 64'h10);
        @(negedge clk);
        chk("r10_pc2", 64'(out_pc), 64'h14);

        // Redirect to unaligned 0x23 while 0x4 is presented
        redirect_to(0);
        wait_pc(4);
        redirect_to(12'h023);
        chk("r23_gap", 64'(out_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("r23_pc", 64'(out_pc), 64'(32'h20 + 4 * k));
            chk("r23_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        chk("r23_halted", 64'(halted), 64'd1);

        // Backpressure at 0x8
        redirect_to(0);
        wait_pc(8);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_pc", 64'(out_pc), 64'h8);
            chk("bp_instr", 64'(out_instr), 64'(rom_word(8)));
            chk("bp_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        chk("bp_take_pc", 64'(out_pc), 64'h8);
        @(negedge clk);
        chk("bp_next_pc", 64'(out_pc), 64'hC);

        // End-of-image with backpressure
        wait_pc(12'h02C);
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("dr_valid", 64'(out_valid), 64'd1);
            chk("dr_pc", 64'(out_pc), 64'h2C);
            chk("dr_halted", 64'(halted), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("dr_halt", 64'(halted), 64'd1);
        chk("dr_valid_off", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-run at 0x18
        redirect_to(12'h010);
        wait_pc(12'h018);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_pc", 64'(out_pc), 64'd0);
        chk("ar_instr", 64'(out_instr), 64'd0);
        chk("ar_halted", 64'(halted), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_first_valid", 64'(out_valid), 64'd1);
        chk("ar_first_pc", 64'(out_pc), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = AW'($urandom_range(0, 4095));
            else
                redirect_pc = AW'($urandom_range(0, END + 7));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        redirect_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the instruction-fetch front end. It owns the program counter, drives the address of the combinational instruction ROM, and registers each fetched word into a single-entry fetch buffer. The buffer's output goes to decode through a valid/ready handshake. The block also accepts PC redirects from later pipeline stages and stops fetching cleanly at the end of the loaded program image.

## Interface
Parameters:
- ADDR_WIDTH, 12, byte-address width of instruction memory
- INSTR_WIDTH, 32, instruction word width
- RESET_PC, 0, PC value after reset; must be a multiple of 4
- END_ADDR, 48, first byte address past the program image
  - Must be a multiple of 4, in the range 4..2**ADDR_WIDTH.
  - The last address fetched is END_ADDR-4.

Ports:
- clk  in  1  Clock. All state updates on the posedge.
- rst_n  in  1  Reset, asynchronous and active-low.
- rom_addr  out  ADDR_WIDTH  Byte address to the instruction ROM; always equals the internal PC.
- rom_data  in  INSTR_WIDTH  ROM read data; combinational from rom_addr, same cycle.
- redirect_valid  in  1  Flush the buffer and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_WIDTH  Redirect target; bits [1:0] are ignored and forced to 0.
- out_valid  out  1  Fetch buffer holds an instruction.
- out_ready  in  1  Decode accepts the buffered instruction this cycle.
- out_pc  out  ADDR_WIDTH  PC of the buffered instruction.
- out_instr  out  INSTR_WIDTH  Buffered instruction.
- halted  out  1  Fetch has stopped at END_ADDR and the buffer is empty.

## Operation
- States: FETCH, DRAIN, HALT. Reset state is FETCH.
- Internal PC is ADDR_WIDTH+1 bits wide.
  - It is compared against END_ADDR at that width, so it never wraps.
  - rom_addr is PC[ADDR_WIDTH-1:0].
- Define `take = out_valid & out_ready` and `load = (state==FETCH) & (PC < END_ADDR) & (!out_valid | out_ready)`.
- FETCH:
  - On load, the buffer captures {PC, rom_data}, out_valid becomes 1, and PC becomes PC+4.
  - If PC >= END_ADDR, there is no load. The next state is DRAIN if the buffer will still hold an instruction (out_valid & !out_ready); otherwise it is HALT.
  - If take occurs without a load, out_valid becomes 0.
- DRAIN:
  - No fetch.
  - On take, out_valid becomes 0 and the state moves to HALT.
- HALT:
  - halted=1, out_valid=0, PC is held.
  - Leaves only on redirect.
- Redirect has highest priority in every state:
  - out_valid becomes 0, discarding any buffered instruction even if take occurs in the same cycle. Decode counts the handshake as consumed.
  - PC becomes {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - State becomes FETCH.
  - No load happens in the redirect cycle.
  - If the target is >= END_ADDR, the next cycle transitions straight to HALT.
- out_pc and out_instr change only on load.
  - They hold their values while out_valid=1 and out_ready=0.
  - After take they retain stale values; these are don't-care while out_valid=0.

## Timing
- Reset (rst_n=0) applies immediately, with no clock needed:
  - PC=RESET_PC, state=FETCH
  - out_valid=0, out_pc=0, out_instr=0, halted=0
- Fetch latency:
  - An instruction at PC appears on out_* one edge after the cycle in which it is presented on rom_addr.
  - The first valid output appears after the first posedge following reset release.
- Throughput is one instruction per cycle while out_ready=1. There are no bubbles between consecutive fetches.
- Backpressure: with out_valid=1 and out_ready=0, PC and the buffer freeze. No instruction is skipped or duplicated.
- Redirect penalty:
  - Edge N samples redirect_valid; out_valid=0 after edge N.
  - The target instruction is valid after edge N+1.
- halted is a registered output. It asserts on the same edge that the state enters HALT and deasserts on the redirect edge.
- Reset asserted mid-operation discards the buffer contents and the redirect state. After release, fetch restarts from RESET_PC.

## Test plan
- Free run, END_ADDR=48, out_ready=1:
  - out_valid=1 for 12 consecutive cycles with out_pc = 0x0, 0x4, …, 0x2C.
  - out_instr matches the ROM word at each address.
  - The cycle after 0x2C is taken: out_valid=0, halted=1, and they stay that way.
- Backpressure: hold out_ready=0 for 3 cycles while out_pc=0x8:
  - out_pc=0x8 and out_instr stay stable.
  - After out_ready returns, the next outputs are 0x8 (taken) then 0xC. No gap, no repeat.
- Redirect while out_pc=0x4 is valid, with redirect_pc=0x23 and out_ready=1:
  - out_valid=0 for one cycle.
  - Then out_pc=0x20, 0x24, 0x28, 0x2C, then halted=1.
- End-of-image with backpressure: out_ready=0 when out_pc=0x2C:
  - The state stays DRAIN and out_valid stays 1.
  - Raising out_ready gives take; halted=1 on the next edge.
- From HALT, redirect_pc=0x10: fetches resume at 0x10. Separately, from HALT, redirect_pc=0x30 (=END_ADDR): one cycle with halted=0, then halted=1, and no instruction is emitted.
- Drop rst_n asynchronously mid-run at out_pc=0x18:
  - out_valid, out_pc, out_instr and halted go to 0 before the next clock edge.
  - After release, the first out_pc is 0x0.
